// File: rtl/avst_timing_pkg.sv
// Shared constants and helpers for the Avalon-ST timing buffer.
package avst_timing_pkg;

  localparam int OVF_CNT_W = 16;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    if (v == {OVF_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + OVF_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/avst_timing_ram.sv
// Buffer storage: DEPTH x DATA_W, one synchronous write port, asynchronous read.
module avst_timing_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/avalon_st_timing_buffer.sv
// First-word-fall-through Avalon-ST buffer for a non-backpressurable source.
// Define AVST_TIMING_BUF_OVF_CNT_EN to build the saturating dropped-beat counter.
module avalon_st_timing_buffer
  import avst_timing_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 out_ready,
  output logic [LVL_W-1:0]     level,
  output logic                 overflow,
  input  logic                 ovf_clear,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             do_rd, do_wr, do_drop;

  // A full buffer still accepts a beat when the head leaves in the same cycle.
  always_comb begin
    do_rd   = out_ready && (level_q != '0);
    do_wr   = in_valid && ((level_q != FULL_LVL) || do_rd);
    do_drop = in_valid && (level_q == FULL_LVL) && !out_ready;

    wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    out_valid_d = (level_d != '0);

    if (do_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef AVST_TIMING_BUF_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;

  // Clear takes precedence over a same-cycle drop.
  always_comb begin
    if (ovf_clear) begin
      ovf_count_d = '0;
    end else if (do_drop) begin
      ovf_count_d = sat_inc(ovf_count_q);
    end else begin
      ovf_count_d = ovf_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_count = ovf_count_q;
`else
  assign ovf_count = {OVF_CNT_W{1'b0}};
`endif

  avst_timing_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (do_wr && reset_n),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/avalon_st_timing_buffer.md
AVALON_ST_TIMING_BUFFER -- requirements
Module: avalon_st_timing_buffer

Interface
REQ-001 SHALL: parameter DATA_W, default 8, payload width in bits (1..512).
REQ-002 SHALL: parameter DEPTH, default 4, buffer entries (power of two, 2..256).
REQ-003 SHALL: parameter LVL_W, default $clog2(DEPTH+1), width of the level output.
REQ-004 SHALL: one clock, clk; reset is synchronous and active-low, reset_n.
REQ-005 SHALL: clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL: reset_n  input  1  synchronous active-low reset.
REQ-007 SHALL: in_valid  input  1  upstream beat present; upstream has no ready and cannot be backpressured.
REQ-008 SHALL: in_data  input  DATA_W  upstream payload.
REQ-009 SHALL: out_valid  output  1  buffer holds at least one beat.
REQ-010 SHALL: out_data  output  DATA_W  head-of-buffer payload.
REQ-011 SHALL: out_ready  input  1  downstream accepts beat (ready latency 0).
REQ-012 SHALL: level  output  LVL_W  current occupancy, 0..DEPTH.
REQ-013 SHALL: overflow  output  1  sticky flag, set when a beat is dropped.
REQ-014 SHALL: ovf_clear  input  1  clears overflow (and ovf_count when compiled in).
REQ-015 SHALL: ovf_count  output  16  dropped-beat count.

Function
REQ-016 SHALL: operate as a first-word-fall-through FIFO; transfer out occurs on out_valid && out_ready.
REQ-017 SHALL: assert out_valid exactly when level != 0; out_data equals the oldest stored beat.
REQ-018 SHALL: give a beat written in cycle N out_valid in cycle N+1 when empty (1-cycle latency, no combinational in->out path).
REQ-019 SHALL: write in_data when in_valid && (level < DEPTH || read this cycle); on a simultaneous read and write, level is unchanged.
REQ-020 SHALL: drop the beat when in_valid && level == DEPTH && !(out_ready); stored contents and level are unchanged.
REQ-021 SHALL: on a drop, set overflow in the following cycle; it holds until ovf_clear or reset.
REQ-022 SHALL: give a simultaneous drop and ovf_clear priority to the set (overflow stays 1).
REQ-023 SHALL: wrap read/write pointers modulo DEPTH with no lost or duplicated beat at the wrap.
REQ-024 SHALL: preserve beat order exactly; out_data stays stable while out_valid && !out_ready.
REQ-025 SHALL: ignore out_ready while level == 0 (no underflow, pointers unchanged).

Reset
REQ-026 SHALL: on reset_n == 0 at a clk edge, clear pointers, level=0, out_valid=0, overflow=0, ovf_count=0; out_data is don't-care.
REQ-027 SHALL: discard buffered beats on reset mid-operation; in_valid during reset is ignored.

Configuration
REQ-028 SHALL: when macro AVST_TIMING_BUF_OVF_CNT_EN is defined, increment ovf_count by 1 per dropped beat, saturating at 16'hFFFF, cleared by ovf_clear (clear wins over increment in the same cycle).
REQ-029 SHALL: when AVST_TIMING_BUF_OVF_CNT_EN is undefined, tie ovf_count to 0 with no counter logic; overflow is unaffected.

Structure
REQ-030 SHALL: place the OVF_CNT_W=16 constant and a saturating-increment function in shared package avst_timing_pkg.
REQ-031 SHALL: implement storage as sub-module avst_timing_ram (DEPTH x DATA_W, one write port, async read), with pointer/level control in the top.

Verification
REQ-032 SHALL: DEPTH=4, out_ready=1, in_valid for 10 cycles with data 0x01..0x0A -> same 10 beats out in order, each 1 cycle later, level never > 1.
REQ-033 SHALL: out_ready=0, write 4 beats 0xA0..0xA3, then 2 more -> level=4, overflow=1 from the cycle after the 5th beat, ovf_count=2 (macro on) / 0 (macro off), output 0xA0..0xA3 after out_ready=1.
REQ-034 SHALL: full buffer, in_valid && out_ready in the same cycle -> no drop, level stays 4, overflow stays 0.
REQ-035 SHALL: 3 beats buffered, reset_n=0 for one cycle -> level=0, out_valid=0 next cycle; a fresh beat 0x55 emerges first afterwards.
REQ-036 SHALL: DATA_W=32, DEPTH=8, random in_valid/out_ready over 20 000 cycles with pointer wrap -> scoreboard match, drop count equals ovf_count, simultaneous drop+ovf_clear leaves overflow=1.
